// File: rtl/fx_bus_arb.sv
// fx_bus_arb: two-master round-robin arbiter and sequencer for the shared fx register bus.
// Latency: write strobe and ack one cycle after grant; read ack RD_LAT+2 cycles after grant.
// Backpressure: a master holds req with a stable command until its ack; the loser waits in IDLE.
//
// Ports: clk_sys/rst_n (async active-low); m0_*/m1_* master request/command/ack/rdata;
//        fx_wr/fx_waddr/fx_data write strobe side, fx_rd/fx_raddr/fx_q read side; busy = not IDLE.
// Optional macro FX_ARB_LOCK_EN: a master whose lock is high in its ack cycle keeps the bus
// until an IDLE sampling edge sees its lock low. Without the macro the lock inputs are ignored.
module fx_bus_arb #(
   parameter int RD_LAT = 1
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [21:0] m0_addr,
   input  logic [7:0]  m0_wdata,
   input  logic        m0_lock,
   output logic        m0_ack,
   output logic [7:0]  m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [21:0] m1_addr,
   input  logic [7:0]  m1_wdata,
   input  logic        m1_lock,
   output logic        m1_ack,
   output logic [7:0]  m1_rdata,
   output logic        fx_wr,
   output logic [21:0] fx_waddr,
   output logic [7:0]  fx_data,
   output logic        fx_rd,
   output logic [21:0] fx_raddr,
   input  logic [7:0]  fx_q,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RACK} state_t;

   // Read wait counter start: zero means fx_q is sampled on the first RWAIT edge.
   localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

   state_t      state;
   logic        rr_last;     // id of the master granted most recently
   logic        gnt;         // id of the master owning the current transaction
   logic [3:0]  cnt;
   logic        elig0;
   logic        elig1;
   logic        pick_vld;
   logic        pick;
   logic        pick_we;
   logic [21:0] pick_addr;
   logic [7:0]  pick_wdata;

`ifdef FX_ARB_LOCK_EN
   logic locked;
   logic lock_id;
   logic gnt_lock;    // lock input of the current transaction owner
   logic owner_lock;  // lock input of the master holding the locked bus
   assign gnt_lock   = gnt ? m1_lock : m0_lock;
   assign owner_lock = lock_id ? m1_lock : m0_lock;
`else
   logic unused_lock;
   assign unused_lock = m0_lock | m1_lock;
`endif

   always_comb begin
      elig0 = m0_req;
      elig1 = m1_req;
`ifdef FX_ARB_LOCK_EN
      // While the owner keeps lock asserted the other master is invisible.
      if (locked && owner_lock) begin
         elig0 = m0_req & ~lock_id;
         elig1 = m1_req & lock_id;
      end
`endif
      pick_vld   = elig0 | elig1;
      // On a tie the master that did not go last wins.
      pick       = (elig0 & elig1) ? ~rr_last : elig1;
      pick_we    = pick ? m1_we    : m0_we;
      pick_addr  = pick ? m1_addr  : m0_addr;
      pick_wdata = pick ? m1_wdata : m0_wdata;
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_last  <= 1'b1;
         gnt      <= 1'b0;
         cnt      <= 4'd0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= 8'h00;
         m1_rdata <= 8'h00;
         fx_wr    <= 1'b0;
         fx_waddr <= 22'h0;
         fx_data  <= 8'h00;
         fx_rd    <= 1'b0;
         fx_raddr <= 22'h0;
         busy     <= 1'b0;
`ifdef FX_ARB_LOCK_EN
         locked   <= 1'b0;
         lock_id  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef FX_ARB_LOCK_EN
               // Release and normal arbitration happen on the same edge.
               if (locked && !owner_lock) locked <= 1'b0;
`endif
               if (pick_vld) begin
                  rr_last <= pick;
                  gnt     <= pick;
                  busy    <= 1'b1;
                  if (pick_we) begin
                     fx_wr    <= 1'b1;
                     fx_waddr <= pick_addr;
                     fx_data  <= pick_wdata;
                     m0_ack   <= ~pick;
                     m1_ack   <= pick;
                     state    <= WR;
                  end else begin
                     fx_rd    <= 1'b1;
                     fx_raddr <= pick_addr;
                     state    <= RD;
                  end
               end
            end
            WR: begin
               fx_wr  <= 1'b0;
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
`ifdef FX_ARB_LOCK_EN
               if (gnt_lock) begin
                  locked  <= 1'b1;
                  lock_id <= gnt;
               end
`endif
            end
            RD: begin
               fx_rd <= 1'b0;
               cnt   <= WAIT_INIT;
               state <= RWAIT;
            end
            RWAIT: begin
               if (cnt == 4'd0) begin
                  if (gnt) begin
                     m1_rdata <= fx_q;
                     m1_ack   <= 1'b1;
                  end else begin
                     m0_rdata <= fx_q;
                     m0_ack   <= 1'b1;
                  end
                  state <= RACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RACK: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
`ifdef FX_ARB_LOCK_EN
               if (gnt_lock) begin
                  locked  <= 1'b1;
                  lock_id <= gnt;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fx_bus_arb.sv
// tb_fx_bus_arb: self-checking bench for fx_bus_arb with a register-slave model on fx_q.
// Instance dut runs RD_LAT=1 for the traffic tests; instance dutb runs RD_LAT=3 for reset-in-RWAIT.
// Expected grant order, strobe/ack cycles, read data and busy come from a transaction-level model.
module tb_fx_bus_arb;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct { logic we; logic [21:0] addr; logic [7:0] wdata; logic lock; } cmd_t;
   typedef struct { int cyc; logic we; logic [21:0] addr; logic [7:0] data; } strb_t;
   typedef struct { int cyc; logic [7:0] rdata; } ack_t;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // instance A signals
   logic        rst_n;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [21:0] m0_addr, m1_addr;
   logic [7:0]  m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack, fx_wr, fx_rd, busy;
   logic [7:0]  m0_rdata, m1_rdata, fx_data, fx_q;
   logic [21:0] fx_waddr, fx_raddr;
   // instance B signals
   logic        b_rst_n;
   logic        b_m0_req, b_m0_we, b_m0_lock, b_m1_req, b_m1_we, b_m1_lock;
   logic [21:0] b_m0_addr, b_m1_addr;
   logic [7:0]  b_m0_wdata, b_m1_wdata;
   logic        b_m0_ack, b_m1_ack, b_fx_wr, b_fx_rd, b_busy;
   logic [7:0]  b_m0_rdata, b_m1_rdata, b_fx_data, b_fx_q;
   logic [21:0] b_fx_waddr, b_fx_raddr;

   fx_bus_arb #(.RD_LAT(LAT_A)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
      .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .busy(busy)
   );

   fx_bus_arb #(.RD_LAT(LAT_B)) dutb (
      .clk_sys(clk_sys), .rst_n(b_rst_n),
      .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_lock(b_m0_lock),
      .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
      .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_lock(b_m1_lock),
      .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
      .fx_wr(b_fx_wr), .fx_waddr(b_fx_waddr), .fx_data(b_fx_data),
      .fx_rd(b_fx_rd), .fx_raddr(b_fx_raddr), .fx_q(b_fx_q), .busy(b_busy)
   );

   // Register map: devices 0..7 have 256 registers each, reset value = low offset byte XOR dev id.
   // Everything else is unmapped and reads 0.
   function automatic logic [7:0] slave_val(input logic [21:0] a);
      if (a[15:8] != 8'h00 || a[21:16] > 6'd7) return 8'h00;
      return a[7:0] ^ {2'b00, a[21:16]};
   endfunction

   // Slave data is valid only RD_LAT cycles after the fx_rd cycle; junk otherwise.
   logic [15:0] hist_a = 16'h0;
   logic [15:0] hist_b = 16'h0;
   logic [7:0]  junk = 8'h00;
   always @(posedge clk_sys) begin
      hist_a <= {hist_a[14:0], fx_rd};
      hist_b <= {hist_b[14:0], b_fx_rd};
   end
   always @(negedge clk_sys) junk <= 8'($urandom);
   assign fx_q   = hist_a[LAT_A-1] ? slave_val(fx_raddr)   : junk;
   assign b_fx_q = hist_b[LAT_B-1] ? slave_val(b_fx_raddr) : junk;

   cmd_t  q0[$];
   cmd_t  q1[$];
   strb_t obs_s[$];
   ack_t  ack0_l[$];
   ack_t  ack1_l[$];
   logic  busy_l[$];
   int    t0;

   function automatic cmd_t mk(input logic we, input logic [21:0] addr, input logic [7:0] d, input logic lock);
      cmd_t c;
      c.we = we; c.addr = addr; c.wdata = d; c.lock = lock;
      return c;
   endfunction

   task automatic drive(input int m, input int i);
      if (m == 0) begin
         if (i < q0.size()) begin
            m0_req = 1'b1; m0_we = q0[i].we; m0_addr = q0[i].addr; m0_wdata = q0[i].wdata; m0_lock = q0[i].lock;
         end else begin
            m0_req = 1'b0; m0_lock = 1'b0;
         end
      end else begin
         if (i < q1.size()) begin
            m1_req = 1'b1; m1_we = q1[i].we; m1_addr = q1[i].addr; m1_wdata = q1[i].wdata; m1_lock = q1[i].lock;
         end else begin
            m1_req = 1'b0; m1_lock = 1'b0;
         end
      end
   endtask

   task automatic reset_pulse();
      @(posedge clk_sys); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1 rst_n = 1'b1;
   endtask

   // Plays q0/q1 as two masters (new command on the edge after each ack) and records the bus.
   task automatic run_traffic();
      int idx0 = 0, idx1 = 0, need, tail = 0, clash = 0;
      bit adv0 = 0, adv1 = 0, done = 0;
      strb_t st;
      ack_t  ak;
      need = q0.size() + q1.size();
      obs_s.delete(); ack0_l.delete(); ack1_l.delete(); busy_l.delete();
      @(posedge clk_sys); #1;
      drive(0, 0); drive(1, 0);
      t0 = cyc;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(posedge clk_sys); #1;
         if (adv0) begin idx0++; drive(0, idx0); adv0 = 0; end
         if (adv1) begin idx1++; drive(1, idx1); adv1 = 0; end
         busy_l.push_back(busy);
         if (fx_wr && fx_rd) clash++;
         if (m0_ack && m1_ack) clash++;
         if (fx_wr) begin st.cyc = cyc; st.we = 1'b1; st.addr = fx_waddr; st.data = fx_data; obs_s.push_back(st); end
         if (fx_rd) begin st.cyc = cyc; st.we = 1'b0; st.addr = fx_raddr; st.data = 8'h00; obs_s.push_back(st); end
         if (m0_ack) begin ak.cyc = cyc; ak.rdata = m0_rdata; ack0_l.push_back(ak); adv0 = 1; end
         if (m1_ack) begin ak.cyc = cyc; ak.rdata = m1_rdata; ack1_l.push_back(ak); adv1 = 1; end
         if (ack0_l.size() + ack1_l.size() >= need) begin
            tail++;
            if (tail > 3) done = 1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL traffic_timeout: acks seen %0d, required %0d", ack0_l.size() + ack1_l.size(), need);
      end
      checks++;
      if (clash !== 0) begin
         errors++;
         $display("FAIL exclusivity: overlapping strobe/ack cycles %0d, required 0", clash);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_sys);
      #1;
      checks++;
      if ({m0_ack, m1_ack, m0_rdata, m1_rdata, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, busy} !== 73'h0) begin
         errors++;
         $display("FAIL reset_outputs_a: got %h, required 0",
                  {m0_ack, m1_ack, m0_rdata, m1_rdata, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, busy});
      end
      checks++;
      if ({b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_fx_wr, b_fx_waddr, b_fx_data, b_fx_rd, b_fx_raddr, b_busy} !== 73'h0) begin
         errors++;
         $display("FAIL reset_outputs_b: got %h, required 0",
                  {b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_fx_wr, b_fx_waddr, b_fx_data, b_fx_rd, b_fx_raddr, b_busy});
      end
      rst_n = 1'b1;
      b_rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [21:0] exp_addr [4];
      exp_addr[0] = 22'h000101; exp_addr[1] = 22'h000103; exp_addr[2] = 22'h000102; exp_addr[3] = 22'h000104;
      q0.delete(); q1.delete();
      q0.push_back(mk(1'b1, 22'h000101, 8'h11, 1'b0));
      q0.push_back(mk(1'b1, 22'h000102, 8'h22, 1'b0));
      q1.push_back(mk(1'b1, 22'h000103, 8'h33, 1'b0));
      q1.push_back(mk(1'b1, 22'h000104, 8'h44, 1'b0));
      run_traffic();
      checks++;
      if (obs_s.size() != 4) begin
         errors++;
         $display("FAIL rr_count: strobes %0d, required 4", obs_s.size());
      end
      for (int k = 0; k < 4 && k < obs_s.size(); k++) begin
         checks++;
         if (obs_s[k].addr !== exp_addr[k] || obs_s[k].cyc !== t0 + 1 + 2 * k) begin
            errors++;
            $display("FAIL rr_order[%0d]: addr %h at cycle %0d, required %h at %0d",
                     k, obs_s[k].addr, obs_s[k].cyc, exp_addr[k], t0 + 1 + 2 * k);
         end
      end
   endtask

   task automatic test_write();
      q0.delete(); q1.delete();
      q0.push_back(mk(1'b1, 22'h000020, 8'h5A, 1'b0));
      run_traffic();
      checks++;
      if (obs_s.size() != 1) begin
         errors++;
         $display("FAIL wr_strobe_count: %0d, required 1", obs_s.size());
      end else if (obs_s[0].we !== 1'b1 || obs_s[0].addr !== 22'h000020 || obs_s[0].data !== 8'h5A) begin
         errors++;
         $display("FAIL wr_strobe: we %b addr %h data %h, required 1 000020 5a", obs_s[0].we, obs_s[0].addr, obs_s[0].data);
      end
      checks++;
      if (ack0_l.size() != 1 || obs_s.size() < 1) begin
         errors++;
         $display("FAIL wr_ack_count: %0d, required 1", ack0_l.size());
      end else if (ack0_l[0].cyc !== obs_s[0].cyc) begin
         errors++;
         $display("FAIL wr_ack_cycle: %0d, required %0d", ack0_l[0].cyc, obs_s[0].cyc);
      end
      checks++;
      if (ack1_l.size() != 0) begin
         errors++;
         $display("FAIL wr_m1_ack: %0d pulses, required 0", ack1_l.size());
      end
   endtask

   task automatic test_read();
      q0.delete(); q1.delete();
      q1.push_back(mk(1'b0, 22'h000080, 8'h00, 1'b0));
      run_traffic();
      checks++;
      if (obs_s.size() != 1) begin
         errors++;
         $display("FAIL rd_strobe_count: %0d, required 1", obs_s.size());
      end else if (obs_s[0].we !== 1'b0 || obs_s[0].addr !== 22'h000080) begin
         errors++;
         $display("FAIL rd_strobe: we %b addr %h, required 0 000080", obs_s[0].we, obs_s[0].addr);
      end
      checks++;
      if (ack1_l.size() != 1 || obs_s.size() < 1) begin
         errors++;
         $display("FAIL rd_ack_count: %0d, required 1", ack1_l.size());
      end else if (ack1_l[0].cyc !== obs_s[0].cyc + 2 || ack1_l[0].rdata !== 8'h80) begin
         errors++;
         $display("FAIL rd_ack: cycle %0d rdata %h, required %0d 80", ack1_l[0].cyc, ack1_l[0].rdata, obs_s[0].cyc + 2);
      end
      checks++;
      if (ack0_l.size() != 0) begin
         errors++;
         $display("FAIL rd_m0_ack: %0d pulses, required 0", ack0_l.size());
      end
   endtask

   task automatic test_unmapped();
      q0.delete(); q1.delete();
      q0.push_back(mk(1'b0, 22'h00FFFF, 8'h00, 1'b0));
      q0.push_back(mk(1'b0, 22'h050000, 8'h00, 1'b0));
      run_traffic();
      checks++;
      if (ack0_l.size() != 2) begin
         errors++;
         $display("FAIL unmapped_ack_count: %0d, required 2", ack0_l.size());
      end else begin
         checks++;
         if (ack0_l[0].rdata !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_rdata: %h, required 00", ack0_l[0].rdata);
         end
         checks++;
         if (ack0_l[1].rdata !== 8'h05) begin
            errors++;
            $display("FAIL dev5_rdata: %h, required 05", ack0_l[1].rdata);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         int n0, n1, rr, i0, i1, s, total;
         bit eb[];
         reset_pulse();
         q0.delete(); q1.delete();
         n0 = $urandom_range(3, 8);
         n1 = $urandom_range(0, 8);
         for (int k = 0; k < n0 + n1; k++) begin
            logic [5:0]  dev;
            logic [15:0] off;
            dev = 6'($urandom_range(0, 9));
            off = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            if (k < n0) q0.push_back(mk(1'($urandom_range(0, 1)), {dev, off}, 8'($urandom), 1'b0));
            else        q1.push_back(mk(1'($urandom_range(0, 1)), {dev, off}, 8'($urandom), 1'b0));
         end
         run_traffic();
         eb = new[busy_l.size()];
         total = n0 + n1;
         rr = 1; i0 = 0; i1 = 0; s = t0 + 1;
         for (int k = 0; k < total; k++) begin
            int m, j, ack_at, na;
            cmd_t c;
            ack_t a;
            if (i0 < n0 && i1 < n1) m = 1 - rr;
            else if (i0 < n0)       m = 0;
            else                    m = 1;
            rr = m;
            j = (m == 0) ? i0 : i1;
            c = (m == 0) ? q0[i0] : q1[i1];
            ack_at = c.we ? s : s + LAT_A + 1;
            checks++;
            if (k >= obs_s.size()) begin
               errors++;
               $display("FAIL rand%0d_strobe[%0d]: missing, required addr %h at %0d", r, k, c.addr, s);
            end else if (obs_s[k].cyc !== s || obs_s[k].we !== c.we || obs_s[k].addr !== c.addr ||
                         (c.we && obs_s[k].data !== c.wdata)) begin
               errors++;
               $display("FAIL rand%0d_strobe[%0d]: cyc %0d we %b addr %h data %h, required %0d %b %h %h",
                        r, k, obs_s[k].cyc, obs_s[k].we, obs_s[k].addr, obs_s[k].data, s, c.we, c.addr, c.wdata);
            end
            na = (m == 0) ? ack0_l.size() : ack1_l.size();
            checks++;
            if (j >= na) begin
               errors++;
               $display("FAIL rand%0d_ack[%0d]: m%0d ack missing, required at %0d", r, k, m, ack_at);
            end else begin
               a = (m == 0) ? ack0_l[j] : ack1_l[j];
               if (a.cyc !== ack_at || (!c.we && a.rdata !== slave_val(c.addr))) begin
                  errors++;
                  $display("FAIL rand%0d_ack[%0d]: m%0d cyc %0d rdata %h, required %0d %h",
                           r, k, m, a.cyc, a.rdata, ack_at, slave_val(c.addr));
               end
            end
            for (int cc = s; cc <= ack_at; cc++)
               if (cc - t0 - 1 < eb.size()) eb[cc - t0 - 1] = 1'b1;
            if (m == 0) i0++; else i1++;
            s += c.we ? 2 : LAT_A + 3;
         end
         checks++;
         if (obs_s.size() != total) begin
            errors++;
            $display("FAIL rand%0d_strobe_total: %0d, required %0d", r, obs_s.size(), total);
         end
         for (int i = 0; i < busy_l.size(); i++) begin
            checks++;
            if (busy_l[i] !== eb[i]) begin
               errors++;
               $display("FAIL rand%0d_busy: cycle %0d busy %b, required %b", r, t0 + 1 + i, busy_l[i], eb[i]);
            end
         end
      end
   endtask

   task automatic test_lock();
      logic [21:0] exp_addr [4];
`ifdef FX_ARB_LOCK_EN
      exp_addr[0] = 22'h000110; exp_addr[1] = 22'h000111; exp_addr[2] = 22'h000112; exp_addr[3] = 22'h000113;
`else
      exp_addr[0] = 22'h000110; exp_addr[1] = 22'h000113; exp_addr[2] = 22'h000111; exp_addr[3] = 22'h000112;
`endif
      reset_pulse();
      q0.delete(); q1.delete();
      q0.push_back(mk(1'b1, 22'h000110, 8'hA0, 1'b1));
      q0.push_back(mk(1'b1, 22'h000111, 8'hA1, 1'b1));
      q0.push_back(mk(1'b1, 22'h000112, 8'hA2, 1'b1));
      q1.push_back(mk(1'b1, 22'h000113, 8'hB3, 1'b0));
      run_traffic();
      checks++;
      if (obs_s.size() != 4) begin
         errors++;
         $display("FAIL lock_count: strobes %0d, required 4", obs_s.size());
      end
      for (int k = 0; k < 4 && k < obs_s.size(); k++) begin
         checks++;
         if (obs_s[k].addr !== exp_addr[k] || obs_s[k].cyc !== t0 + 1 + 2 * k) begin
            errors++;
            $display("FAIL lock_order[%0d]: addr %h at %0d, required %h at %0d",
                     k, obs_s[k].addr, obs_s[k].cyc, exp_addr[k], t0 + 1 + 2 * k);
         end
      end
   endtask

   task automatic test_reset_mid();
      int s = -1, s2 = -1, ack_cyc = -1, acks = 0;
      logic [7:0] rd = 8'h00;
      @(posedge clk_sys); #1;
      b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 22'h050000;
      for (int i = 0; i < 10 && s < 0; i++) begin
         @(posedge clk_sys); #1;
         if (b_fx_rd) s = cyc;
      end
      checks++;
      if (s < 0) begin
         errors++;
         $display("FAIL rmid_strobe: no fx_rd within 10 cycles, required one");
      end
      @(posedge clk_sys); #1;
      b_rst_n = 1'b0;
      #1;
      checks++;
      if ({b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_fx_wr, b_fx_waddr, b_fx_data, b_fx_rd, b_fx_raddr, b_busy} !== 73'h0) begin
         errors++;
         $display("FAIL rmid_async_clear: got %h, required 0",
                  {b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_fx_wr, b_fx_waddr, b_fx_data, b_fx_rd, b_fx_raddr, b_busy});
      end
      repeat (2) begin
         @(posedge clk_sys); #1;
         if (b_m0_ack) acks++;
      end
      b_rst_n = 1'b1;
      for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
         @(posedge clk_sys); #1;
         if (b_fx_rd && s2 < 0) s2 = cyc;
         if (b_m0_ack) begin acks++; ack_cyc = cyc; rd = b_m0_rdata; end
      end
      @(posedge clk_sys); #1;
      b_m0_req = 1'b0;
      checks++;
      if (acks !== 1) begin
         errors++;
         $display("FAIL rmid_ack_count: %0d, required 1", acks);
      end
      checks++;
      if (ack_cyc < 0 || s2 < 0 || ack_cyc !== s2 + LAT_B + 1 || rd !== 8'h05) begin
         errors++;
         $display("FAIL rmid_reissue: ack at %0d rdata %h, required at %0d rdata 05", ack_cyc, rd, s2 + LAT_B + 1);
      end
   endtask

   initial begin
      rst_n = 1'b0; b_rst_n = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 22'h0; m0_wdata = 8'h00; m0_lock = 1'b0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 22'h0; m1_wdata = 8'h00; m1_lock = 1'b0;
      b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 22'h0; b_m0_wdata = 8'h00; b_m0_lock = 1'b0;
      b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 22'h0; b_m1_wdata = 8'h00; b_m1_lock = 1'b0;
      test_reset();
      test_round_robin();
      test_write();
      test_read();
      test_unmapped();
      test_random();
      test_lock();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
